// File: rtl/draw_fill.sv
// draw_fill: solid-colour fill engine for VRAM over an AXI4 write master.
//
// A fill writes NBURST bursts of 8 x 64-bit beats (64 bytes each), starting
// at BASEADDR rounded down to 64 bytes. Every beat carries the 32-bit COLOR
// replicated across the data word. Only one burst is in flight at a time:
// AW handshake -> 8 W beats -> B response -> next burst.
//
// Ports
//   ACLK, ARST        clock, synchronous active-high reset
//   START             one-cycle fill request (ignored while BUSY)
//   BASEADDR          first byte address, bits [5:0] ignored
//   COLOR             xRGB8888 pixel value
//   NBURST            number of 64-byte bursts (0 = immediate DONE)
//   BUSY / DONE / ERR fill in progress / end-of-fill pulse / sticky BRESP error
//   M_AXI_AW*         write address channel (INCR, 8 beats, 8 bytes/beat)
//   M_AXI_W*          write data channel
//   M_AXI_B*          write response channel
module draw_fill #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 64   // only 64 is supported
) (
  input  logic                              ACLK,
  input  logic                              ARST,
  input  logic                              START,
  input  logic [31:0]                       BASEADDR,
  input  logic [31:0]                       COLOR,
  input  logic [15:0]                       NBURST,
  output logic                              BUSY,
  output logic                              DONE,
  output logic                              ERR,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [7:0]                        M_AXI_AWLEN,
  output logic [2:0]                        M_AXI_AWSIZE,
  output logic [1:0]                        M_AXI_AWBURST,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WLAST,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY
);

  localparam int AW        = C_M_AXI_ADDR_WIDTH;
  localparam int NUM_LANES = C_M_AXI_DATA_WIDTH / 32;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t      state, state_n;
  logic [AW-1:0] addr_q;
  logic [31:0] color_q;
  logic [15:0] remaining;
  logic [2:0]  beat;
  logic        done_q;
  logic        err_q;

  // 64-byte alignment is what keeps every burst inside one 4 KB page.
  logic [31:0] base_al;
  assign base_al = BASEADDR & ~32'h0000_003F;

  logic aw_hs, w_hs, wlast_hs, b_hs, last_burst;
  assign aw_hs      = (state == ADDR) && M_AXI_AWREADY;
  assign w_hs       = (state == DATA) && M_AXI_WREADY;
  assign wlast_hs   = w_hs && (beat == 3'd7);
  assign b_hs       = (state == RESP) && M_AXI_BVALID;
  assign last_burst = (remaining == 16'd1);

  // state register
  always_ff @(posedge ACLK) begin
    if (ARST) state <= IDLE;
    else      state <= state_n;
  end

  // next state + channel outputs
  always_comb begin
    state_n       = state;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_WLAST   = 1'b0;
    M_AXI_BREADY  = 1'b0;
    case (state)
      IDLE: if (START && (NBURST != 16'd0)) state_n = ADDR;
      ADDR: begin
        M_AXI_AWVALID = 1'b1;
        if (aw_hs) state_n = DATA;
      end
      DATA: begin
        M_AXI_WVALID = 1'b1;
        M_AXI_WLAST  = (beat == 3'd7);
        if (wlast_hs) state_n = RESP;
      end
      RESP: begin
        M_AXI_BREADY = 1'b1;
        if (b_hs) state_n = last_burst ? IDLE : ADDR;
      end
      default: state_n = IDLE;
    endcase
  end

  // datapath: latched fill parameters, beat/burst counters, status
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      addr_q    <= '0;
      color_q   <= '0;
      remaining <= '0;
      beat      <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (START) begin
          addr_q    <= AW'(base_al);
          color_q   <= COLOR;
          remaining <= NBURST;
          beat      <= '0;
          err_q     <= 1'b0;
          // empty fill completes without touching the bus
          if (NBURST == 16'd0) done_q <= 1'b1;
        end
        // 3-bit counter wraps back to 0 after beat 7, ready for next burst
        DATA: if (w_hs) beat <= beat + 3'd1;
        RESP: if (b_hs) begin
          remaining <= remaining - 16'd1;
          addr_q    <= addr_q + AW'(64);
          if (M_AXI_BRESP != 2'b00) err_q <= 1'b1;
          if (last_burst) done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign BUSY          = (state != IDLE);
  assign DONE          = done_q;
  assign ERR           = err_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWLEN   = 8'd7;
  assign M_AXI_AWSIZE  = 3'b011;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_WSTRB   = '1;

  // pixel replicated into each 32-bit lane of the data word
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign M_AXI_WDATA[g*32 +: 32] = color_q;
  end

endmodule

// File: tb/tb_draw_fill.sv
// tb_draw_fill: directed self-checking bench for draw_fill.
module tb_draw_fill;

  logic        ACLK = 1'b0;
  logic        ARST, START;
  logic [31:0] BASEADDR, COLOR;
  logic [15:0] NBURST;
  logic        BUSY, DONE, ERR;
  logic [31:0] AWADDR;
  logic        AWVALID, AWREADY;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic        WLAST, WVALID, WREADY;
  logic [1:0]  BRESP;
  logic        BVALID, BREADY;

  draw_fill dut (
    .ACLK(ACLK), .ARST(ARST), .START(START), .BASEADDR(BASEADDR),
    .COLOR(COLOR), .NBURST(NBURST), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_AWLEN(AWLEN), .M_AXI_AWSIZE(AWSIZE), .M_AXI_AWBURST(AWBURST),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WLAST(WLAST),
    .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
    .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY)
  );

  always #5 ACLK = ~ACLK;

  int tests = 0;
  int fails = 0;

  // stimulus controls
  bit          stall_en  = 0;
  bit          bresp_err = 0;   // BRESP=2'b10 on the first B handshake only
  logic [31:0] exp_color = '0;
  logic        mon_clr   = 0;

  // bus monitor
  int          aw_cnt, w_cnt, b_cnt, done_cnt, awv_seen;
  int          beat_in;
  logic [31:0] aw_log [0:15];
  bit          overlap, wdata_bad, wlast_bad, stable_bad, const_bad;
  logic        aw_stall, w_stall;
  logic [31:0] prev_addr;
  logic [63:0] prev_wdata;

  always @(posedge ACLK) begin
    if (mon_clr) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; done_cnt <= 0; awv_seen <= 0;
      beat_in <= 0; overlap <= 0; wdata_bad <= 0; wlast_bad <= 0;
      stable_bad <= 0; const_bad <= 0; aw_stall <= 0; w_stall <= 0;
    end else begin
      if (AWVALID && WVALID) overlap <= 1;
      if (AWVALID) awv_seen <= awv_seen + 1;
      if (AWVALID && AWREADY) begin
        aw_log[aw_cnt % 16] <= AWADDR;
        aw_cnt <= aw_cnt + 1;
        if (AWLEN !== 8'd7 || AWSIZE !== 3'b011 || AWBURST !== 2'b01) const_bad <= 1;
      end
      if (WVALID && WREADY) begin
        w_cnt <= w_cnt + 1;
        if (WDATA !== {exp_color, exp_color} || WSTRB !== 8'hFF) wdata_bad <= 1;
        if (WLAST !== (beat_in == 7)) wlast_bad <= 1;
        beat_in <= (beat_in == 7) ? 0 : beat_in + 1;
      end
      if (BVALID && BREADY) b_cnt <= b_cnt + 1;
      if (DONE) done_cnt <= done_cnt + 1;
      if (aw_stall && (AWVALID !== 1'b1 || AWADDR !== prev_addr)) stable_bad <= 1;
      if (w_stall && (WVALID !== 1'b1 || WDATA !== prev_wdata)) stable_bad <= 1;
      aw_stall   <= AWVALID && !AWREADY;
      w_stall    <= WVALID && !WREADY;
      prev_addr  <= AWADDR;
      prev_wdata <= WDATA;
    end
  end

  task automatic clr_mon();
    mon_clr = 1;
    @(negedge ACLK);
    mon_clr = 0;
  endtask

  task automatic drive_resp();
    if (stall_en) begin
      AWREADY = 1'($urandom_range(0, 1));
      WREADY  = 1'($urandom_range(0, 1));
      BVALID  = 1'($urandom_range(0, 1));
    end else begin
      AWREADY = 1; WREADY = 1; BVALID = 1;
    end
    BRESP = (bresp_err && b_cnt == 0) ? 2'b10 : 2'b00;
  endtask

  // pulse START for one cycle; returns on the negedge after the START edge
  task automatic do_start(input logic [31:0] base, input logic [31:0] col,
                          input logic [15:0] nb);
    BASEADDR = base; COLOR = col; NBURST = nb; START = 1;
    drive_resp();
    @(negedge ACLK);
    START = 0;
  endtask

  // kind 0: DONE, 1: b_cnt >= target, 2: w_cnt >= target
  task automatic run_until(input int kind, input int target, input int budget,
                           output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if ((kind == 0 && DONE) || (kind == 1 && b_cnt >= target) ||
          (kind == 2 && w_cnt >= target)) begin
        ok = 1;
        break;
      end
      drive_resp();
      @(negedge ACLK);
    end
  endtask

  task automatic chk_ok(input string name, input bit ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL %s: timed out waiting", name); end
  endtask

  task automatic test_reset();
    ARST = 1;
    repeat (3) @(negedge ACLK);
    tests++;
    if ({BUSY, DONE, ERR, AWVALID, WVALID, WLAST, BREADY} !== 7'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b want 0000000",
               {BUSY, DONE, ERR, AWVALID, WVALID, WLAST, BREADY});
    end
    ARST = 0;
    @(negedge ACLK);
  endtask

  task automatic test_single();
    bit ok;
    clr_mon(); exp_color = 32'h1234_5678;
    do_start(32'h1000_0010, 32'h1234_5678, 16'd1);
    tests++;
    if (BUSY !== 1'b1 || AWVALID !== 1'b1 || AWADDR !== 32'h1000_0000) begin
      fails++;
      $display("FAIL single_addr: busy=%b awvalid=%b awaddr=%h want 1 1 10000000",
               BUSY, AWVALID, AWADDR);
    end
    run_until(0, 0, 200, ok); chk_ok("single_done", ok);
    tests++;
    if (BUSY !== 1'b0) begin fails++; $display("FAIL single_busy_at_done: got %b want 0", BUSY); end
    @(negedge ACLK);
    tests++;
    if (aw_cnt !== 1 || w_cnt !== 8 || done_cnt !== 1 || DONE !== 1'b0) begin
      fails++;
      $display("FAIL single_counts: aw=%0d w=%0d done=%0d DONE=%b want 1 8 1 0",
               aw_cnt, w_cnt, done_cnt, DONE);
    end
    tests++;
    if (wlast_bad || wdata_bad || const_bad || overlap) begin
      fails++;
      $display("FAIL single_beats: wlast_bad=%b wdata_bad=%b const_bad=%b overlap=%b want 0",
               wlast_bad, wdata_bad, const_bad, overlap);
    end
  endtask

  task automatic test_multi(input string name, input logic [31:0] base,
                            input logic [31:0] col, input logic [31:0] a0,
                            input logic [31:0] a1, input logic [31:0] a2);
    bit ok;
    clr_mon(); exp_color = col;
    do_start(base, col, 16'd3);
    run_until(0, 0, 2000, ok); chk_ok(name, ok);
    @(negedge ACLK);
    tests++;
    if (aw_cnt !== 3 || aw_log[0] !== a0 || aw_log[1] !== a1 || aw_log[2] !== a2) begin
      fails++;
      $display("FAIL %s_addrs: n=%0d %h %h %h want 3 %h %h %h",
               name, aw_cnt, aw_log[0], aw_log[1], aw_log[2], a0, a1, a2);
    end
    tests++;
    if (w_cnt !== 24 || wdata_bad || wlast_bad || stable_bad || overlap || BUSY) begin
      fails++;
      $display("FAIL %s_data: w=%0d wdata_bad=%b wlast_bad=%b stable_bad=%b overlap=%b busy=%b want 24 0 0 0 0 0",
               name, w_cnt, wdata_bad, wlast_bad, stable_bad, overlap, BUSY);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    clr_mon(); exp_color = 32'h0000_00AA;
    do_start(32'hFFFF_FFC5, 32'h0000_00AA, 16'd2);
    run_until(0, 0, 200, ok); chk_ok("wrap_done", ok);
    @(negedge ACLK);
    tests++;
    if (aw_cnt !== 2 || aw_log[0] !== 32'hFFFF_FFC0 || aw_log[1] !== 32'h0000_0000) begin
      fails++;
      $display("FAIL wrap_addrs: n=%0d %h %h want 2 ffffffc0 00000000",
               aw_cnt, aw_log[0], aw_log[1]);
    end
  endtask

  task automatic test_zero();
    clr_mon();
    do_start(32'h2000_0000, 32'h0, 16'd0);
    tests++;
    if (DONE !== 1'b1) begin fails++; $display("FAIL zero_done: got %b want 1", DONE); end
    repeat (6) begin drive_resp(); @(negedge ACLK); end
    tests++;
    if (awv_seen !== 0 || done_cnt !== 1 || BUSY !== 1'b0) begin
      fails++;
      $display("FAIL zero_nobus: awvalid_cycles=%0d done=%0d busy=%b want 0 1 0",
               awv_seen, done_cnt, BUSY);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clr_mon(); exp_color = 32'h00C0_FFEE;
    do_start(32'h4000_0000, 32'h00C0_FFEE, 16'd2);
    repeat (3) begin drive_resp(); @(negedge ACLK); end
    do_start(32'h5000_0000, 32'h0BAD_0BAD, 16'd5);   // must be ignored
    run_until(0, 0, 400, ok); chk_ok("ignore_done", ok);
    @(negedge ACLK);
    tests++;
    if (aw_cnt !== 2 || aw_log[0] !== 32'h4000_0000 || aw_log[1] !== 32'h4000_0040 ||
        w_cnt !== 16 || wdata_bad) begin
      fails++;
      $display("FAIL ignore_start: n=%0d %h %h w=%0d wdata_bad=%b want 2 40000000 40000040 16 0",
               aw_cnt, aw_log[0], aw_log[1], w_cnt, wdata_bad);
    end
    repeat (4) begin drive_resp(); @(negedge ACLK); end
    tests++;
    if (BUSY !== 1'b0 || aw_cnt !== 2) begin
      fails++;
      $display("FAIL ignore_idle: busy=%b aw=%0d want 0 2", BUSY, aw_cnt);
    end
  endtask

  task automatic test_err();
    bit ok;
    clr_mon(); exp_color = 32'h0000_FF00; bresp_err = 1;
    do_start(32'h6000_0000, 32'h0000_FF00, 16'd2);
    run_until(1, 1, 200, ok); chk_ok("err_b1", ok);
    tests++;
    if (ERR !== 1'b1 || BUSY !== 1'b1) begin
      fails++;
      $display("FAIL err_mid: err=%b busy=%b want 1 1", ERR, BUSY);
    end
    run_until(0, 0, 200, ok); chk_ok("err_done", ok);
    repeat (3) begin drive_resp(); @(negedge ACLK); end
    bresp_err = 0;
    tests++;
    if (ERR !== 1'b1 || aw_cnt !== 2) begin
      fails++;
      $display("FAIL err_sticky: err=%b aw=%0d want 1 2", ERR, aw_cnt);
    end
    do_start(32'h6000_1000, 32'h0000_FF00, 16'd1);
    tests++;
    if (ERR !== 1'b0) begin fails++; $display("FAIL err_clear: got %b want 0", ERR); end
    run_until(0, 0, 200, ok); chk_ok("err_clear_done", ok);
    @(negedge ACLK);
  endtask

  task automatic test_reset_mid();
    bit ok;
    clr_mon(); exp_color = 32'h0011_2233;
    do_start(32'h7000_0000, 32'h0011_2233, 16'd2);
    run_until(2, 3, 200, ok); chk_ok("rst_reach_beat4", ok);
    ARST = 1;
    @(negedge ACLK);
    tests++;
    if (BUSY !== 1'b0 || WVALID !== 1'b0 || AWVALID !== 1'b0 || BREADY !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid: busy=%b wvalid=%b awvalid=%b bready=%b want 0 0 0 0",
               BUSY, WVALID, AWVALID, BREADY);
    end
    ARST = 0;
    clr_mon();
    repeat (5) begin drive_resp(); @(negedge ACLK); end
    tests++;
    if (awv_seen !== 0 || w_cnt !== 0 || done_cnt !== 0) begin
      fails++;
      $display("FAIL rst_no_resume: awvalid_cycles=%0d w=%0d done=%0d want 0 0 0",
               awv_seen, w_cnt, done_cnt);
    end
    exp_color = 32'h0044_5566;
    do_start(32'h7100_0040, 32'h0044_5566, 16'd1);
    run_until(0, 0, 200, ok); chk_ok("rst_fresh_done", ok);
    @(negedge ACLK);
    tests++;
    if (aw_cnt !== 1 || aw_log[0] !== 32'h7100_0040 || w_cnt !== 8 || wdata_bad || wlast_bad) begin
      fails++;
      $display("FAIL rst_fresh: n=%0d addr=%h w=%0d wdata_bad=%b wlast_bad=%b want 1 71000040 8 0 0",
               aw_cnt, aw_log[0], w_cnt, wdata_bad, wlast_bad);
    end
  endtask

  initial begin
    ARST = 1; START = 0; BASEADDR = '0; COLOR = '0; NBURST = '0;
    AWREADY = 1; WREADY = 1; BVALID = 1; BRESP = 2'b00;
    @(negedge ACLK);
    test_reset();
    test_single();
    test_multi("multi", 32'h2000_0000, 32'h00FF_8040,
               32'h2000_0000, 32'h2000_0040, 32'h2000_0080);
    stall_en = 1;
    test_multi("stall", 32'h3000_0FC0, 32'h00AB_CDEF,
               32'h3000_0FC0, 32'h3000_1000, 32'h3000_1040);
    stall_en = 0;
    test_wrap();
    test_zero();
    test_back_to_back();
    test_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
